// File: rtl/store_buffer.sv
// ============================================================================
// Module   : store_buffer
// Summary  : FIFO of CPU stores drained to a handshaked memory, with store-to-
//            load forwarding. Optional in-place store coalescing is enabled by
//            defining STORE_BUF_COALESCE_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module store_buffer #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_we,
    input  logic          cpu_re,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ack,
    input  logic [DW-1:0] mem_rdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int TW = AW - 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW:0]    count_q, count_d;
    logic [TW-1:0]  tag_q  [DEPTH];
    logic [TW-1:0]  tag_d  [DEPTH];
    logic [DW-1:0]  data_q [DEPTH];
    logic [DW-1:0]  data_d [DEPTH];

    logic [TW-1:0]  cpu_tag;
    logic           match;
    logic [PW-1:0]  match_idx;
    logic [PW-1:0]  scan_idx;
    logic           load_act, load_hit, load_miss;
    logic           pop, push, full, coalesce;
    logic           unused_addr_bits;

    assign cpu_tag          = cpu_addr[AW-1:2];
    assign unused_addr_bits = ^cpu_addr[1:0];

    // Scan oldest to youngest so the last hit is the youngest matching entry.
    always_comb begin
        match     = 1'b0;
        match_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = rd_ptr_q + k[PW-1:0];
            if (((PW+1)'(k) < count_q) && (tag_q[scan_idx] == cpu_tag)) begin
                match     = 1'b1;
                match_idx = scan_idx;
            end
        end
    end

    assign load_act  = cpu_re && !cpu_we;
    assign load_hit  = load_act && match;
    assign load_miss = load_act && !match;
    assign pop       = (state_q == WRITE) && mem_ack;
    assign full      = (count_q == (PW+1)'(DEPTH));

`ifdef STORE_BUF_COALESCE_EN
    // The head under an active write must keep its data stable, so it is never merged into.
    assign coalesce = cpu_we && match && !((state_q == WRITE) && (match_idx == rd_ptr_q));
`else
    assign coalesce = 1'b0;
`endif

    assign push  = cpu_we && !coalesce && (!full || pop);
    assign stall = !reset &&
                   ((cpu_we && !coalesce && full && !pop) ||
                    (load_miss && !((state_q == READ) && mem_ack)));

    always_comb begin
        cpu_rdata = '0;
        if (!reset) begin
            if (load_hit) begin
                cpu_rdata = data_q[match_idx];
            end else if (load_miss && (state_q == READ) && mem_ack) begin
                cpu_rdata = mem_rdata;
            end
        end
    end

    always_comb begin
        tag_d    = tag_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            tag_d[wr_ptr_q]  = cpu_tag;
            data_d[wr_ptr_q] = cpu_wdata;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (coalesce) begin
            data_d[match_idx] = cpu_wdata;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    // A load miss takes priority over draining; it can never alias a buffered store.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (load_miss) begin
                    state_d = READ;
                end else if (count_q != '0) begin
                    state_d = WRITE;
                end
            end
            WRITE:   if (mem_ack) state_d = IDLE;
            READ:    if (mem_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: occupancy is tracked by count and pointers.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign mem_req = (state_q != IDLE);
    assign mem_we  = (state_q == WRITE);

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            WRITE: begin
                mem_addr  = {tag_q[rd_ptr_q], 2'b00};
                mem_wdata = data_q[rd_ptr_q];
            end
            READ:    mem_addr = {cpu_tag, 2'b00};
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_store_buffer.sv
// ============================================================================
// Module   : tb_store_buffer
// Summary  : Directed scoreboard bench for store_buffer; expected memory
//            transactions and load results are queued and checked by a monitor.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_store_buffer;

    logic        clk;
    logic        reset;
    logic        cpu_we, cpu_re;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        stall;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_t;

    mem_t        exp_mem[$];
    logic [31:0] exp_ld[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    store_buffer #(.DEPTH(4), .DW(32), .AW(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_we    (cpu_we),
        .cpu_re    (cpu_re),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .stall     (stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        cpu_we    = 1'b1;
        cpu_addr  = a;
        cpu_wdata = d;
        @(negedge clk);
        chk("store_no_stall", 32'(stall), 32'd0);
        tick();
        cpu_we = 1'b0;
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
        mem_t m;
        m.we = 1'b1; m.addr = a; m.data = d;
        exp_mem.push_back(m);
    endtask

    task automatic exp_rd(input logic [31:0] a);
        mem_t m;
        m.we = 1'b0; m.addr = a; m.data = 32'd0;
        exp_mem.push_back(m);
    endtask

    // Acknowledge the next memory request, waiting at most budget cycles.
    task automatic do_ack(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            if (mem_req) begin
                mem_ack = 1'b1;
                done    = 1'b1;
            end
            tick();
        end
        mem_ack = 1'b0;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ack_timeout: got no mem_req expected mem_req within %0d cycles", budget);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_req && mem_ack) begin
                if (exp_mem.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL mem_unexpected: got addr %h we %0d expected none", mem_addr, mem_we);
                end else begin
                    mem_t m;
                    m = exp_mem.pop_front();
                    chk("mem_we", 32'(mem_we), 32'(m.we));
                    chk("mem_addr", mem_addr, m.addr);
                    if (m.we) chk("mem_wdata", mem_wdata, m.data);
                end
            end
            if (cpu_re && !cpu_we && !stall) begin
                if (exp_ld.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL load_unexpected: got %h expected none", cpu_rdata);
                end else begin
                    chk("load_data", cpu_rdata, exp_ld.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cpu_we = 1'b0; cpu_re = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        tick();

        // Store then immediate forwarded load; drain begins one edge later.
        store(32'h40, 32'h11);
        cpu_re = 1'b1; cpu_addr = 32'h40; exp_ld.push_back(32'h11);
        @(negedge clk);
        chk("fwd_stall", 32'(stall), 32'd0);
        tick();
        cpu_re = 1'b0;
        @(negedge clk);
        chk("drain_req", 32'(mem_req), 32'd1);
        chk("drain_we", 32'(mem_we), 32'd1);
        chk("drain_addr", mem_addr, 32'h40);
        exp_wr(32'h40, 32'h11);
        do_ack(5);

        // Fill to full, fifth store stalls until a pop frees a slot.
        for (int i = 0; i < 4; i++) store(32'(i * 4), 32'hA0 + 32'(i));
        cpu_we = 1'b1; cpu_addr = 32'h14; cpu_wdata = 32'hA4;
        @(negedge clk);
        chk("full_stall0", 32'(stall), 32'd1);
        tick();
        @(negedge clk);
        chk("full_stall1", 32'(stall), 32'd1);
        tick();
        exp_wr(32'h0, 32'hA0);
        mem_ack = 1'b1;
        @(negedge clk);
        chk("full_pop_stall", 32'(stall), 32'd0);
        tick();
        cpu_we = 1'b0; mem_ack = 1'b0;
        cpu_re = 1'b1; cpu_addr = 32'h14; exp_ld.push_back(32'hA4);
        @(negedge clk);
        chk("fwd_tail_stall", 32'(stall), 32'd0);
        tick();
        cpu_re = 1'b0;
        exp_wr(32'h4, 32'hA1); exp_wr(32'h8, 32'hA2);
        exp_wr(32'hC, 32'hA3); exp_wr(32'h14, 32'hA4);
        repeat (4) do_ack(10);

        // Load miss on an empty buffer, acked on the fourth cycle.
        cpu_re = 1'b1; cpu_addr = 32'h80;
        @(negedge clk);
        chk("miss_stall_c0", 32'(stall), 32'd1);
        tick();
        @(negedge clk);
        chk("miss_stall_c1", 32'(stall), 32'd1);
        chk("miss_req", 32'(mem_req), 32'd1);
        chk("miss_we", 32'(mem_we), 32'd0);
        chk("miss_addr", mem_addr, 32'h80);
        tick();
        @(negedge clk);
        chk("miss_stall_c2", 32'(stall), 32'd1);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hDEAD;
        exp_rd(32'h80); exp_ld.push_back(32'hDEAD);
        @(negedge clk);
        chk("miss_ack_stall", 32'(stall), 32'd0);
        tick();
        cpu_re = 1'b0; mem_ack = 1'b0;

        // Two stores to one word.
        store(32'h10, 32'h5);
        store(32'h10, 32'h6);
        cpu_re = 1'b1; cpu_addr = 32'h10; exp_ld.push_back(32'h6);
        @(negedge clk);
        tick();
        cpu_re = 1'b0;
`ifdef STORE_BUF_COALESCE_EN
        exp_wr(32'h10, 32'h6);
        do_ack(10);
`else
        exp_wr(32'h10, 32'h5); exp_wr(32'h10, 32'h6);
        repeat (2) do_ack(10);
`endif
        @(negedge clk);
        chk("dup_drained_a", 32'(mem_req), 32'd0);
        tick();
        @(negedge clk);
        chk("dup_drained_b", 32'(mem_req), 32'd0);
        tick();

        // Load miss arriving during an in-flight write.
        store(32'h20, 32'h7);
        tick();
        cpu_re = 1'b1; cpu_addr = 32'h100;
        @(negedge clk);
        chk("wmiss_stall", 32'(stall), 32'd1);
        chk("wmiss_we", 32'(mem_we), 32'd1);
        chk("wmiss_addr0", mem_addr, 32'h20);
        tick();
        @(negedge clk);
        chk("wmiss_addr1", mem_addr, 32'h20);
        tick();
        exp_wr(32'h20, 32'h7);
        mem_ack = 1'b1;
        @(negedge clk);
        chk("wmiss_ack_stall", 32'(stall), 32'd1);
        tick();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("wmiss_idle_gap", 32'(mem_req), 32'd0);
        chk("wmiss_gap_stall", 32'(stall), 32'd1);
        tick();
        @(negedge clk);
        chk("wmiss_rd_we", 32'(mem_we), 32'd0);
        chk("wmiss_rd_addr0", mem_addr, 32'h100);
        tick();
        @(negedge clk);
        chk("wmiss_rd_addr1", mem_addr, 32'h100);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hBEEF;
        exp_rd(32'h100); exp_ld.push_back(32'hBEEF);
        @(negedge clk);
        tick();
        cpu_re = 1'b0; mem_ack = 1'b0;

        // Reset during a write with three entries buffered.
        store(32'h200, 32'h1);
        store(32'h204, 32'h2);
        store(32'h208, 32'h3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_req", 32'(mem_req), 32'd0);
        chk("rst_mid_stall", 32'(stall), 32'd0);
        tick();
        cpu_re = 1'b1; cpu_addr = 32'h204;
        @(negedge clk);
        chk("rst_load_miss", 32'(stall), 32'd1);
        chk("rst_load_rdata", cpu_rdata, 32'd0);
        tick();
        @(negedge clk);
        chk("rst_rd_addr", mem_addr, 32'h204);
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h55;
        exp_rd(32'h204); exp_ld.push_back(32'h55);
        @(negedge clk);
        tick();
        cpu_re = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        chk("rst_empty_a", 32'(mem_req), 32'd0);
        tick();
        @(negedge clk);
        chk("rst_empty_b", 32'(mem_req), 32'd0);

        chk("mem_queue_left", 32'(exp_mem.size()), 32'd0);
        chk("load_queue_left", 32'(exp_ld.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Sits between the single-cycle CPU data port and a slow, handshaked data memory.
- Queues CPU stores in a FIFO and drains them to memory in the background.
- Forwards buffered data to loads that hit in the buffer; stalls the CPU only on a full buffer or a load miss.

Parameters:
- DEPTH, 4, number of buffered stores (power of 2, at least 2)
- DW, 32, data width
- AW, 32, byte address width; word tag is addr[AW-1:2]

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_we  in  1  store request (from CPU memwrite)
- cpu_re  in  1  load request
- cpu_addr  in  AW  byte address; bits [1:0] ignored
- cpu_wdata  in  DW  store data
- cpu_rdata  out  DW  load data, combinational
- stall  out  1  CPU must hold its state and inputs this cycle
- mem_req  out  1  memory transaction valid
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  AW  word-aligned address, bits [1:0] = 0
- mem_wdata  out  DW  write data
- mem_ack  in  1  transaction complete this cycle; read data valid in mem_rdata
- mem_rdata  in  DW  read data

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset:
  - count = 0, read/write pointers = 0, state = IDLE.
  - mem_req = 0, stall = 0, cpu_rdata = 0.
  - Reset mid-transaction abandons the in-flight transaction and discards all buffered stores.
- Entry: {tag = addr[AW-1:2], data}.
- Store path:
  - If cpu_we and (not full, or a pop occurs this cycle), push at the edge.
  - Otherwise stall = 1 and nothing is pushed.
  - cpu_we together with cpu_re is treated as a store; cpu_re is ignored.
- Forwarding:
  - A load with cpu_re = 1 compares its tag against all valid entries.
  - On a match, cpu_rdata = data of the youngest matching entry, in the same cycle, with no stall.
- Load miss:
  - stall = 1 until the read completes.
  - stall drops in the cycle mem_ack = 1 during READ, and cpu_rdata = mem_rdata in that cycle.
- cpu_rdata is 0 when no load is active.
- FSM states: IDLE, WRITE, READ.
  - IDLE: load miss goes to READ; otherwise non-empty goes to WRITE; otherwise stay in IDLE. A load miss has priority over draining, which is safe because a miss never aliases a buffered store.
  - WRITE: mem_req = 1, mem_we = 1, address/data from the head entry, held stable. On mem_ack, pop the head and return to IDLE.
  - READ: mem_req = 1, mem_we = 0, mem_addr = {cpu_addr tag, 2'b00}. On mem_ack, return to IDLE.
- Outputs: mem_req and mem_we decode from the state register only. mem_addr and mem_wdata are 0 in IDLE.
- Timing: a store pushed at edge k into an empty buffer, with no load miss, gives mem_req = 1 from edge k+1.
- A write already in progress is never preempted; a load miss arriving during WRITE waits for that write's ack.
- Full buffer plus pop in the same cycle: push is accepted and count is unchanged.
- Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Back-to-back transactions have at least one IDLE cycle between acks.

Optional Feature:
- Macro: STORE_BUF_COALESCE_EN.
- Defined: a store whose tag matches a valid entry overwrites that entry's data in place, with no push. Tags are therefore unique.
- Exception: if the matching entry is the head and state = WRITE, the store is pushed as a new entry, so presented data stays stable.
- Coalescing is allowed even when the buffer is full (no stall).
- Undefined: every store pushes; duplicates are allowed; forwarding picks the youngest match.

Test Plan:
- Store 0x11 to 0x40, then load 0x40 next cycle with mem_ack held 0 → cpu_rdata = 0x11, stall = 0; mem_req = 1, mem_we = 1, mem_addr = 0x40.
- Four stores to 0x0/0x4/0x8/0xC with mem_ack = 0, then a fifth store → stall = 1. Pulse mem_ack → head popped, fifth store accepted that cycle, stall = 0.
- Load 0x80 (miss) with empty buffer, memory acks after 3 cycles with 0xDEAD → stall high for 3 cycles and drops on the ack cycle; cpu_rdata = 0xDEAD.
- Store 0x5 to 0x10, then store 0x6 to 0x10 → without the macro, two writes are drained and a load forwards 0x6; with STORE_BUF_COALESCE_EN, one write of 0x6 is drained (if the first write had not yet started).
- Load miss to 0x100 arriving during an in-flight write → write completes first, then READ of 0x100; mem_addr stable while each mem_req is unacked.
- reset asserted during WRITE with 3 entries buffered → next cycle: mem_req = 0, stall = 0, buffer empty; a load of a previously buffered address misses.
